// File: rtl/window_buffer_pkg.sv
// Shared window geometry and pixel/position types for the 3x3 window buffer.
package window_buffer_pkg;

  localparam int WIN_SIZE           = 3;
  localparam int WIN_TAPS           = WIN_SIZE * WIN_SIZE;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int POS_WIDTH          = 16;

  typedef logic [DATA_WIDTH_DEFAULT-1:0] pixel_t;
  typedef logic [POS_WIDTH-1:0]          pos_t;

endpackage

// File: rtl/line_delay.sv
// Fixed-length pixel delay line; shifts one position per enabled cycle.
module line_delay #(
  parameter int LENGTH = 720,
  parameter int WIDTH  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [LENGTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LENGTH; i++) mem[i] <= '0;
    end else if (enable) begin
      mem[0] <= data_in;
      for (int i = 1; i < LENGTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign data_out = mem[LENGTH-1];

endmodule

// File: rtl/window_buffer.sv
// Raster-scan 3x3 window generator with a single registered output stage.
// Optional centre-position outputs are enabled by defining WINDOW_BUFFER_POS_EN.
module window_buffer
  import window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] out_window,
  output logic                           out_valid,
  input  logic                           out_ready
`ifdef WINDOW_BUFFER_POS_EN
  ,
  output logic [POS_WIDTH-1:0]           out_col,
  output logic [POS_WIDTH-1:0]           out_row
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(WIN_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_SIZE - 1);

  logic [CW-1:0]                  col;
  logic [RW-1:0]                  row;
  logic                           in_xfer;
  logic                           emit;
  logic [DATA_WIDTH-1:0]          ld0_out;
  logic [DATA_WIDTH-1:0]          ld1_out;
  logic [DATA_WIDTH-1:0]          tap      [WIN_SIZE][WIN_SIZE];
  logic [DATA_WIDTH-1:0]          tap_next [WIN_SIZE][WIN_SIZE];
  logic [WIN_TAPS*DATA_WIDTH-1:0] win_next;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign emit     = in_xfer && (row >= ROW_FIRST) && (col >= COL_FIRST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // ld0 yields the pixel one line above the incoming one, ld1 two lines above
  line_delay #(.LENGTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_line0 (
    .clock    (clock),
    .reset    (reset),
    .enable   (in_xfer),
    .data_in  (in_data),
    .data_out (ld0_out)
  );

  line_delay #(.LENGTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_line1 (
    .clock    (clock),
    .reset    (reset),
    .enable   (in_xfer),
    .data_in  (ld0_out),
    .data_out (ld1_out)
  );

  always_comb begin
    tap_next = '{default: '0};
    win_next = '0;
    for (int i = 0; i < WIN_SIZE; i++)
      for (int j = 0; j < WIN_SIZE - 1; j++)
        tap_next[i][j] = tap[i][j+1];
    tap_next[0][WIN_SIZE-1] = ld1_out;
    tap_next[1][WIN_SIZE-1] = ld0_out;
    tap_next[2][WIN_SIZE-1] = in_data;
    for (int i = 0; i < WIN_SIZE; i++)
      for (int j = 0; j < WIN_SIZE; j++)
        win_next[(WIN_SIZE*i + j)*DATA_WIDTH +: DATA_WIDTH] = tap_next[i][j];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tap <= '{default: '0};
    end else if (in_xfer) begin
      tap <= tap_next;
    end
  end

  // A qualifying input during an output transfer reloads without a bubble
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_window <= '0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_window <= win_next;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef WINDOW_BUFFER_POS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_col <= '0;
      out_row <= '0;
    end else if (emit) begin
      out_col <= POS_WIDTH'(col) - POS_WIDTH'(1);
      out_row <= POS_WIDTH'(row) - POS_WIDTH'(1);
    end
  end
`endif

endmodule
